// File: rtl/ps2_move_queue.sv
// Turns PS/2 key-press edges into move commands and queues them for the cube-rotation engine.
// Define MOVE_CANCEL_EN to let a push of a move's inverse remove the matching tail entry.
module ps2_move_queue #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CODE_W = 4,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] key_code,
  input  logic              key_pressed,
  output logic              move_valid,
  output logic [CODE_W-1:0] move_code,
  input  logic              move_ready,
  output logic [ADDR_W:0]   q_count,
  output logic              overflow
);

  localparam logic [CODE_W-1:0] CodeMin   = CODE_W'(2);
  localparam logic [CODE_W-1:0] CodeMax   = CODE_W'(13);
  localparam logic [ADDR_W:0]   CountFull = (ADDR_W+1)'(DEPTH);

  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [CODE_W-1:0] code_q;
  logic              pressed_q;
  logic              overflow_q;

  logic code_ok, push_ev, pop, cancel, wr_en, drop;

  assign code_ok = (key_code >= CodeMin) && (key_code <= CodeMax);
  // A new press is a rising edge, or a different key appearing while still held.
  assign push_ev = key_pressed && code_ok && (!pressed_q || (key_code != code_q));
  assign pop     = (count_q != '0) && move_ready;

`ifdef MOVE_CANCEL_EN
  localparam logic [CODE_W-1:0] InvMask  = CODE_W'(1);
  localparam logic [ADDR_W:0]   CountOne = (ADDR_W+1)'(1);
  logic [ADDR_W-1:0] tail_ptr;
  assign tail_ptr = wr_ptr_q - 1'b1;
  // A lone tail that is leaving this cycle cannot be cancelled; the push is queued instead.
  assign cancel = push_ev && (count_q != '0) &&
                  (mem_q[tail_ptr] == (key_code ^ InvMask)) &&
                  !((count_q == CountOne) && pop);
`else
  assign cancel = 1'b0;
`endif

  assign wr_en = push_ev && !cancel && ((count_q != CountFull) || pop);
  assign drop  = push_ev && !cancel && !wr_en;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_d - 1'b1;
    end
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      count_d  = count_d + 1'b1;
    end
    if (cancel) begin
      wr_ptr_d = wr_ptr_q - 1'b1;
      count_d  = count_d - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      pressed_q  <= 1'b0;
      code_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      pressed_q  <= key_pressed;
      code_q     <= key_code;
      overflow_q <= drop;
    end
  end

  // Storage is reset so that move_code reads 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= key_code;
    end
  end

  assign move_valid = (count_q != '0);
  assign move_code  = mem_q[rd_ptr_q];
  assign q_count    = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_move_queue.sv
// Randomised and scripted bench for ps2_move_queue against a queue-based reference model.
module tb_ps2_move_queue;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned CODE_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CODE_W-1:0] key_code = '0;
  logic              key_pressed = 1'b0;
  logic              move_valid;
  logic [CODE_W-1:0] move_code;
  logic              move_ready = 1'b0;
  logic [3:0]        q_count;
  logic              overflow;

  ps2_move_queue #(.DEPTH(DEPTH), .CODE_W(CODE_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_code   (key_code),
    .key_pressed(key_pressed),
    .move_valid (move_valid),
    .move_code  (move_code),
    .move_ready (move_ready),
    .q_count    (q_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: queued moves, previous key inputs, pending drop pulse.
  int q[$];
  int prev_p = 0;
  int prev_c = 0;
  int exp_ovf = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".valid"}, int'(move_valid), (q.size() != 0) ? 1 : 0);
    if (q.size() != 0) check_eq({tag, ".code"}, int'(move_code), q[0]);
    check_eq({tag, ".count"}, int'(q_count), q.size());
    check_eq({tag, ".ovf"}, int'(overflow), exp_ovf);
  endtask

  function automatic void model_reset();
    q.delete();
    prev_p  = 0;
    prev_c  = 0;
    exp_ovf = 0;
  endfunction

  // Apply one cycle of inputs, advance the model by the same rules, then compare.
  task automatic step(input int p, input int c, input int r, input string tag);
    int push, pop, canc;
    key_pressed = p[0];
    key_code    = c[CODE_W-1:0];
    move_ready  = r[0];
    push = (p != 0) && (c >= 2) && (c <= 13) && (prev_p == 0 || c != prev_c);
    pop  = (q.size() != 0) && (r != 0);
    canc = 0;
`ifdef MOVE_CANCEL_EN
    if (push && q.size() >= 1 && q[$] == (c ^ 1) && !(q.size() == 1 && pop)) canc = 1;
`endif
    exp_ovf = 0;
    if (canc) void'(q.pop_back());
    if (pop) void'(q.pop_front());
    if (push && !canc) begin
      if (q.size() < DEPTH) q.push_back(c);
      else exp_ovf = 1;
    end
    prev_p = p;
    prev_c = c;
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic press(input int c, input int r);
    step(1, c, r, "press");
    step(0, c, r, "release");
  endtask

  initial begin
    int p, c, r, rdy_pct;
    model_reset();
    @(negedge clk);
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single press, then hold, then change key while held.
    step(1, 2, 0, "first");
    check_eq("first.code_const", int'(move_code), 2);
    for (int i = 0; i < 50; i++) step(1, 2, 0, "hold");
    check_eq("hold.count_const", int'(q_count), 1);
    step(1, 8, 0, "chg");
    check_eq("chg.count_const", int'(q_count), 2);
    for (int i = 0; i < 3; i++) step(0, 8, 1, "drain");

    // Fill to DEPTH, ninth press is dropped.
    begin
      int codes[9] = '{2, 4, 6, 8, 10, 12, 2, 4, 6};
      for (int i = 0; i < 8; i++) press(codes[i], 0);
      step(1, codes[8], 0, "ninth");
      check_eq("ninth.ovf_const", int'(overflow), 1);
      check_eq("ninth.count_const", int'(q_count), 8);
      step(0, codes[8], 0, "ninth_rel");
    end
    // Push with simultaneous pop while full.
    step(1, 12, 1, "fullpp");
    check_eq("fullpp.count_const", int'(q_count), 8);
    check_eq("fullpp.ovf_const", int'(overflow), 0);
    for (int i = 0; i < 8; i++) step(1, 12, 1, "popall");
    check_eq("popall.valid_const", int'(move_valid), 0);
    step(0, 0, 0, "idle");

    // Invalid codes never push.
    press(0, 0);
    press(14, 0);
    press(15, 0);
    check_eq("invalid.count_const", int'(q_count), 0);

    // Reset mid-operation with five entries, key held through release.
    press(2, 0); press(4, 0); press(6, 0); press(8, 0);
    step(1, 10, 0, "five");
    check_eq("five.count_const", int'(q_count), 5);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    check_eq("async_rst.code", int'(move_code), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 10, 0, "held_thru_rst");
    step(0, 10, 1, "clr");

`ifdef MOVE_CANCEL_EN
    press(6, 0);
    press(7, 0);
    check_eq("cancel.count_const", int'(q_count), 0);
    press(6, 0);
    step(1, 7, 1, "nocancel");
    check_eq("nocancel.count_const", int'(q_count), 1);
    check_eq("nocancel.code_const", int'(move_code), 7);
    step(0, 7, 1, "nocancel_rel");
`endif

    // Random phases with different consumer duty cycles.
    p = 0;
    c = 2;
    for (int ph = 0; ph < 4; ph++) begin
      rdy_pct = (ph == 0) ? 10 : (ph == 1) ? 50 : (ph == 2) ? 90 : 30;
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(99) < 35) p = 1 - p;
        if ($urandom_range(99) < 40) c = $urandom_range(15);
        r = ($urandom_range(99) < rdy_pct) ? 1 : 0;
        step(p, c, r, "rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
